lc3_control_fsm: RTL and testbench
==================================

Name: lc3_control_fsm

Overview:
- Moore control unit that sequences the LC-3 datapath (PC, PC mux, MAR, MDR, MDR mux, IR, bus mux, address adder, ALU, register file) through fetch, decode and execute.
- Supports the opcode subset ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE.
- Handles fixed-latency SRAM waits and the Run/Continue front-panel buttons.
- Sits beside the datapath inside the CPU top level; all datapath load enables, gates and mux selects come only from this block.

Parameters:
- MEM_WAIT, 2, number of cycles a memory read/write state is held (range 1..7).
- FETCH_PAUSE, 0, when 1, insert a PauseIR1/PauseIR2 stop after every fetch (single-step debug).

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; forces Halted.
- Run  in  1  start execution from Halted (level).
- Continue  in  1  resume from a pause state (level).
- Opcode  in  4  IR[15:12].
- IR_5  in  1  IR[5]; selects immediate vs register for ADD/AND.
- IR_11  in  1  IR[11]; JSR vs JSRR.
- BEN  in  1  registered branch-enable from the datapath.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high in any cycle.
- PCMUX  out  2  0=PC+1, 1=address adder, 2=Bus.
- DRMUX  out  1  0=IR[11:9], 1=R7.
- SR1MUX  out  1  0=IR[11:9], 1=IR[8:6].
- SR2MUX  out  1  0=register, 1=sext imm5.
- ADDR1MUX  out  1  0=PC, 1=SR1.
- ADDR2MUX  out  2  0=zero, 1=off6, 2=off9, 3=off11.
- ALUK  out  2  0=ADD, 1=AND, 2=NOT, 3=pass A.
- MIO_EN  out  1  1=MDR loads from memory, 0=from Bus.
- Mem_OE_n, Mem_WE_n  out  1 each  SRAM strobes, active-low.
- State  out  5  current state encoding, for debug/LEDs.

Behaviour:
- Interface timing: one clock, Clk; reset is synchronous and active-high (Reset).
- Reset: state=Halted, wait counter=0. All enables, gates and selects are 0; Mem_OE_n=Mem_WE_n=1.
- Outputs: Moore only; decoded combinationally from state. Any enable or select not listed below is 0 in that state.
- Halted: Run=1 -> S18; otherwise stay.
- Fetch:
  - S18: GatePC, LD_MAR, PCMUX=0, LD_PC -> S33.
  - S33: Mem_OE_n=0, MIO_EN=1. Held MEM_WAIT cycles via counter; LD_MDR only in the final cycle -> S35.
  - S35: GateMDR, LD_IR -> PauseIR1 if FETCH_PAUSE, else S32.
- Pause:
  - PauseIR1: LD_LED. Stay while Continue=0; Continue=1 -> PauseIR2.
  - PauseIR2: stay while Continue=1; Continue=0 -> S18.
  - This gives one step per button press/release.
- S32 decode: LD_BEN. Next state by opcode:
  - 0001 -> S01; 0101 -> S05; 1001 -> S09; 0000 -> S00; 1100 -> S12; 0100 -> S04; 0110 -> S06; 0111 -> S07; 1101 -> PauseIR1.
  - Any other opcode -> S18 (executes as NOP).
- S01/S05/S09: SR1MUX=1, SR2MUX=IR_5, ALUK=0/1/2, GateALU, LD_REG, LD_CC, DRMUX=0 -> S18.
- Branch:
  - S00: BEN=1 -> S22, else S18. BEN is sampled in S00, i.e. one cycle after LD_BEN.
  - S22: ADDR1MUX=0, ADDR2MUX=2, PCMUX=1, LD_PC -> S18.
- S12 (JMP): SR1MUX=1, ADDR1MUX=1, ADDR2MUX=0, PCMUX=1, LD_PC -> S18.
- S04: GatePC, DRMUX=1, LD_REG (R7<-PC) -> S21.
- S21: IR_11=1 gives ADDR1MUX=0, ADDR2MUX=3; IR_11=0 gives ADDR1MUX=1, SR1MUX=1, ADDR2MUX=0. Both: PCMUX=1, LD_PC -> S18.
  - The R7 write in S04 precedes the PC change, so JSRR R7 jumps to the new R7 value.
- LDR:
  - S06: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=1, GateMARMUX, LD_MAR -> S25.
  - S25: same as S33 -> S27.
  - S27: GateMDR, DRMUX=0, LD_REG, LD_CC -> S18.
- STR:
  - S07: same as S06 -> S23.
  - S23: SR1MUX=0, ALUK=3, GateALU, MIO_EN=0, LD_MDR -> S16.
  - S16: Mem_WE_n=0 held MEM_WAIT cycles -> S18.
- Wait counter:
  - Cleared on every state change.
  - Increments while held in S33/S25/S16.
  - Exits when count == MEM_WAIT-1.
- Reset mid-operation: takes priority over every transition. A pending write is abandoned: Mem_WE_n returns to 1 the cycle after Reset is sampled.
- Run is ignored outside Halted. Continue is ignored outside the pause states.

Decomposition:
- Package lc3_pkg:
  - state_t enum.
  - Opcode constants: OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_JSR, OP_LDR, OP_STR, OP_PSE.
  - Mux encodings: PCMUX_INC/ADDR/BUS, ADDR2_* and ALUK_*.
- One sub-module, lc3_mem_wait_ctr: the wait counter. Inputs: Clk, Reset, clr, en. Output: done.

Test Plan:
- Reset high 2 cycles with Run=1 -> State=Halted and all strobes inactive. Release Reset with Run=1 -> next cycles S18, S33×2, S35, S32.
- Opcode=0001, IR_5=1 after fetch -> S01 asserts GateALU, LD_REG, LD_CC, SR2MUX=1, ALUK=0 for exactly 1 cycle, then S18.
- Opcode=0000: BEN=0 -> S32, S00, S18. BEN=1 -> S00, S22 with PCMUX=1, ADDR2MUX=2, LD_PC.
- Opcode=0111 with MEM_WAIT=3 -> LD_MAR in S07; LD_MDR with MIO_EN=0 in S23; Mem_WE_n=0 for exactly 3 cycles.
- Opcode=1101 -> PauseIR1 with LD_LED held while Continue=0. Continue 0->1->0 -> PauseIR2 then S18; Continue held 1 stays in PauseIR2.
- Reset pulsed during the second S16 cycle -> Mem_WE_n=1 and State=Halted next cycle. Opcode=1111 -> S32 -> S18.

Source files
------------

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared state, opcode and mux encodings for the LC-3 control unit
package lc3_pkg;

  // State encodings; the numbered states keep their LC-3 state number where it fits in 5 bits
  typedef enum logic [4:0] {
    S_00      = 5'd0,
    S_01      = 5'd1,
    S_04      = 5'd4,
    S_05      = 5'd5,
    S_06      = 5'd6,
    S_07      = 5'd7,
    S_HALTED  = 5'd8,
    S_09      = 5'd9,
    S_32      = 5'd10,
    S_33      = 5'd11,
    S_12      = 5'd12,
    S_35      = 5'd13,
    S_PAUSE1  = 5'd14,
    S_PAUSE2  = 5'd15,
    S_16      = 5'd16,
    S_18      = 5'd18,
    S_21      = 5'd21,
    S_22      = 5'd22,
    S_23      = 5'd23,
    S_25      = 5'd25,
    S_27      = 5'd27
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC  = 2'd0;
  localparam logic [1:0] PCMUX_ADDR = 2'd1;
  localparam logic [1:0] PCMUX_BUS  = 2'd2;

  localparam logic [1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2_OFF6  = 2'd1;
  localparam logic [1:0] ADDR2_OFF9  = 2'd2;
  localparam logic [1:0] ADDR2_OFF11 = 2'd3;

  localparam logic [1:0] ALUK_ADD  = 2'd0;
  localparam logic [1:0] ALUK_AND  = 2'd1;
  localparam logic [1:0] ALUK_NOT  = 2'd2;
  localparam logic [1:0] ALUK_PASS = 2'd3;

endpackage

// File: rtl/lc3_mem_wait_ctr.sv
// rtl/lc3_mem_wait_ctr.sv - counts cycles spent in a memory access state
module lc3_mem_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] count;

  // Clear on reset or state change, otherwise count held cycles
  always_ff @(posedge Clk) begin
    if (Reset || clr)
      count <= 3'd0;
    else if (en)
      count <= count + 3'd1;
  end

  assign done = (count == LAST);

endmodule

// File: rtl/lc3_control_fsm.sv
// rtl/lc3_control_fsm.sv - Moore control unit sequencing the LC-3 datapath
module lc3_control_fsm
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT    = 2,
  parameter bit FETCH_PAUSE = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       Mem_OE_n,
  output logic       Mem_WE_n,
  output logic [4:0] State
);

  state_t state;
  state_t next_state;
  logic   wait_done;
  logic   wait_en;
  logic   wait_clr;

  assign wait_en  = (state == S_33) || (state == S_25) || (state == S_16);
  assign wait_clr = (next_state != state);

  lc3_mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (wait_clr),
    .en    (wait_en),
    .done  (wait_done)
  );

  // State register; reset overrides every transition
  always_ff @(posedge Clk) begin
    if (Reset)
      state <= S_HALTED;
    else
      state <= next_state;
  end

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      S_HALTED: if (Run) next_state = S_18;
      S_18:     next_state = S_33;
      S_33:     if (wait_done) next_state = S_35;
      S_35:     next_state = FETCH_PAUSE ? S_PAUSE1 : S_32;
      S_PAUSE1: if (Continue) next_state = S_PAUSE2;
      S_PAUSE2: if (!Continue) next_state = S_18;
      S_32: begin
        case (Opcode)
          OP_ADD:  next_state = S_01;
          OP_AND:  next_state = S_05;
          OP_NOT:  next_state = S_09;
          OP_BR:   next_state = S_00;
          OP_JMP:  next_state = S_12;
          OP_JSR:  next_state = S_04;
          OP_LDR:  next_state = S_06;
          OP_STR:  next_state = S_07;
          OP_PSE:  next_state = S_PAUSE1;
          default: next_state = S_18;
        endcase
      end
      S_01, S_05, S_09: next_state = S_18;
      S_00:     next_state = BEN ? S_22 : S_18;
      S_22:     next_state = S_18;
      S_12:     next_state = S_18;
      S_04:     next_state = S_21;
      S_21:     next_state = S_18;
      S_06:     next_state = S_25;
      S_25:     if (wait_done) next_state = S_27;
      S_27:     next_state = S_18;
      S_07:     next_state = S_23;
      S_23:     next_state = S_16;
      S_16:     if (wait_done) next_state = S_18;
      default:  next_state = S_HALTED;
    endcase
  end

  // Moore output decode; everything idle unless the state asks for it
  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_INC;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALUK_ADD;
    MIO_EN     = 1'b0;
    Mem_OE_n   = 1'b1;
    Mem_WE_n   = 1'b1;
    case (state)
      S_18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        PCMUX  = PCMUX_INC;
        LD_PC  = 1'b1;
      end
      S_33, S_25: begin
        Mem_OE_n = 1'b0;
        MIO_EN   = 1'b1;
        LD_MDR   = wait_done;
      end
      S_35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_PAUSE1: LD_LED = 1'b1;
      S_32:     LD_BEN = 1'b1;
      S_01, S_05, S_09: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state == S_01) ? ALUK_ADD : (state == S_05) ? ALUK_AND : ALUK_NOT;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_22: begin
        ADDR2MUX = ADDR2_OFF9;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
      end
      S_12: begin
        SR1MUX   = 1'b1;
        ADDR1MUX = 1'b1;
        PCMUX    = PCMUX_ADDR;
        LD_PC    = 1'b1;
      end
      S_04: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_21: begin
        if (IR_11) begin
          ADDR2MUX = ADDR2_OFF11;
        end else begin
          ADDR1MUX = 1'b1;
          SR1MUX   = 1'b1;
        end
        PCMUX = PCMUX_ADDR;
        LD_PC = 1'b1;
      end
      S_06, S_07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_OFF6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_23: begin
        ALUK    = ALUK_PASS;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_16:    Mem_WE_n = 1'b0;
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb/tb_lc3_control_fsm.sv - directed self-checking bench for lc3_control_fsm
module tb_lc3_control_fsm;
  import lc3_pkg::*;

  localparam int MW = 3;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE_n, Mem_WE_n;
  logic [4:0] State;

  int checks = 0;
  int errors = 0;
  int we_cycles;

  lc3_control_fsm #(.MEM_WAIT(MW), .FETCH_PAUSE(1'b0)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
    .Mem_OE_n(Mem_OE_n), .Mem_WE_n(Mem_WE_n), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and check the bus drivers never collide
  task automatic tick();
    @(posedge Clk);
    #1;
    chk("gate_onehot", 8'(32'(GatePC) + 32'(GateMDR) + 32'(GateALU) + 32'(GateMARMUX) <= 1), 8'd1);
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, {3'b000, State}, {3'b000, 5'(exp)});
  endtask

  // Walk from S18 through the memory read into decode
  task automatic do_fetch();
    for (int i = 0; i < MW; i++) begin
      tick();
      chk_st("fetch_s33", S_33);
      chk("fetch_oe", {7'd0, Mem_OE_n}, 8'd0);
      chk("fetch_ldmdr", {7'd0, LD_MDR}, (i == MW - 1) ? 8'd1 : 8'd0);
    end
    tick();
    chk_st("fetch_s35", S_35);
    chk("s35_ldir", {6'd0, GateMDR, LD_IR}, 8'd3);
    tick();
    chk_st("decode_s32", S_32);
    chk("s32_ldben", {7'd0, LD_BEN}, 8'd1);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b1; Continue = 1'b0; Opcode = OP_ADD;
    IR_5 = 1'b1; IR_11 = 1'b1; BEN = 1'b0;
    tick(); tick();
    chk_st("reset_halted", S_HALTED);
    chk("reset_strobes", {6'd0, Mem_OE_n, Mem_WE_n}, 8'd3);
    chk("reset_loads", {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED}, 8'd0);

    // Leave reset with Run held: fetch then ADD immediate
    Reset = 1'b0;
    tick();
    chk_st("run_s18", S_18);
    chk("s18_ctl", {GatePC, LD_MAR, LD_PC, 3'd0, PCMUX}, 8'b1110_0000);
    Run = 1'b0;
    do_fetch();
    tick();
    chk_st("add_s01", S_01);
    chk("add_ctl", {GateALU, LD_REG, LD_CC, SR2MUX, SR1MUX, 1'b0, ALUK}, 8'b1111_1000);
    tick();
    chk_st("add_done", S_18);
    chk("add_regoff", {7'd0, LD_REG}, 8'd0);

    // BR not taken
    Opcode = OP_BR; BEN = 1'b0;
    do_fetch();
    tick(); chk_st("br0_s00", S_00);
    tick(); chk_st("br0_s18", S_18);

    // BR taken
    BEN = 1'b1;
    do_fetch();
    tick(); chk_st("br1_s00", S_00);
    tick(); chk_st("br1_s22", S_22);
    chk("br1_ctl", {LD_PC, ADDR1MUX, PCMUX, 2'd0, ADDR2MUX}, 8'b1001_0010);
    tick(); chk_st("br1_s18", S_18);
    BEN = 1'b0;

    // JSR with offset
    Opcode = OP_JSR; IR_11 = 1'b1;
    do_fetch();
    tick(); chk_st("jsr_s04", S_04);
    chk("jsr_r7", {5'd0, GatePC, DRMUX, LD_REG}, 8'd7);
    tick(); chk_st("jsr_s21", S_21);
    chk("jsr_ctl", {LD_PC, ADDR1MUX, PCMUX, 2'd0, ADDR2MUX}, 8'b1001_0011);
    tick(); chk_st("jsr_s18", S_18);

    // LDR
    Opcode = OP_LDR;
    do_fetch();
    tick(); chk_st("ldr_s06", S_06);
    chk("ldr_mar", {4'd0, GateMARMUX, LD_MAR, 2'(ADDR2MUX)}, 8'b0000_1101);
    for (int i = 0; i < MW; i++) begin
      tick(); chk_st("ldr_s25", S_25);
    end
    tick(); chk_st("ldr_s27", S_27);
    chk("ldr_ctl", {5'd0, GateMDR, LD_REG, LD_CC}, 8'd7);
    tick(); chk_st("ldr_s18", S_18);

    // STR with write strobe width check
    Opcode = OP_STR;
    do_fetch();
    tick(); chk_st("str_s07", S_07);
    chk("str_mar", {6'd0, GateMARMUX, LD_MAR}, 8'd3);
    tick(); chk_st("str_s23", S_23);
    chk("str_mdr", {4'd0, LD_MDR, MIO_EN, ALUK}, 8'b0000_1011);
    we_cycles = 0;
    for (int i = 0; i < 10 && State != 5'(S_18); i++) begin
      tick();
      if (Mem_WE_n == 1'b0) we_cycles++;
    end
    chk("str_we_cycles", 8'(we_cycles), 8'(MW));
    chk_st("str_s18", S_18);
    chk("str_we_off", {7'd0, Mem_WE_n}, 8'd1);

    // PAUSE, one step per press/release
    Opcode = OP_PSE; Continue = 1'b0;
    do_fetch();
    tick(); chk_st("pse_p1", S_PAUSE1);
    chk("pse_led", {7'd0, LD_LED}, 8'd1);
    tick(); chk_st("pse_p1_hold", S_PAUSE1);
    chk("pse_led_hold", {7'd0, LD_LED}, 8'd1);
    Continue = 1'b1;
    tick(); chk_st("pse_p2", S_PAUSE2);
    tick(); chk_st("pse_p2_hold", S_PAUSE2);
    Continue = 1'b0;
    tick(); chk_st("pse_s18", S_18);

    // Reset during second S16 cycle abandons the write
    Opcode = OP_STR;
    do_fetch();
    tick(); tick(); chk_st("rst_s23", S_23);
    tick(); chk_st("rst_s16a", S_16);
    tick(); chk_st("rst_s16b", S_16);
    chk("rst_we_low", {7'd0, Mem_WE_n}, 8'd0);
    Reset = 1'b1;
    tick(); chk_st("rst_halted", S_HALTED);
    chk("rst_we_high", {7'd0, Mem_WE_n}, 8'd1);
    Reset = 1'b0;
    tick(); chk_st("rst_stay", S_HALTED);
    Run = 1'b1;
    tick(); chk_st("rst_rerun", S_18);
    Run = 1'b0;

    // Undefined opcode acts as NOP
    Opcode = 4'b1111;
    do_fetch();
    tick(); chk_st("nop_s18", S_18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
